// File: rtl/fp32_normalizer.sv
// rtl/fp32_normalizer.sv - FP32 adder-tree back end: normalize, round to nearest-even, pack
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   sum_in            two's-complement sum of aligned mantissas (implied 1 at ALIGN_POINT)
//   max_exp_in        shared maximum biased exponent of the operands
//   any_nan_in        some operand was NaN
//   inf_pos_in        some operand was +inf
//   inf_neg_in        some operand was -inf
//   out_valid/out_ready output handshake
//   result            packed IEEE-754 single-precision result
//   overflow          finite sum rounded to infinity
//   underflow         result is denormal or zero and inexact
//   inexact           nonzero bits discarded by rounding
module fp32_normalizer #(
  parameter int SUM_WIDTH   = 31,
  parameter int ALIGN_POINT = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] sum_in,
  input  logic [7:0]           max_exp_in,
  input  logic                 any_nan_in,
  input  logic                 inf_pos_in,
  input  logic                 inf_neg_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  localparam int MAG_W = SUM_WIDTH - 1;
  localparam int P_W   = $clog2(MAG_W);

  // Pipeline control: a stage loads when empty or when its content moves on.
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  // ---------------------------------------------------------------- S1
  logic             s1_sign;
  logic [MAG_W-1:0] s1_mag;
  logic [9:0]       s1_exp;
  logic             s1_nan, s1_infp, s1_infn;
  logic [MAG_W-1:0] abs_mag;

  // The sum never reaches -2^MAG_W, so negating the low bits alone is exact.
  assign abs_mag = sum_in[SUM_WIDTH-1] ? (~sum_in[MAG_W-1:0] + MAG_W'(1))
                                       : sum_in[MAG_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (load1) begin
      v1      <= in_valid;
      s1_sign <= sum_in[SUM_WIDTH-1];
      s1_mag  <= abs_mag;
      // Denormal operands share the scale of exponent 1.
      s1_exp  <= (max_exp_in == 8'd0) ? 10'd1 : {2'b00, max_exp_in};
      s1_nan  <= any_nan_in;
      s1_infp <= inf_pos_in;
      s1_infn <= inf_neg_in;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [P_W-1:0]   lead;
  logic [9:0]       x_unb;
  logic             is_norm;
  logic [MAG_W-1:0] norm;
  logic [25:0]      dn;

  always_comb begin
    lead = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (s1_mag[i]) lead = P_W'(i);
    end
  end

  assign x_unb   = s1_exp + 10'(lead) - 10'(ALIGN_POINT);
  assign is_norm = $signed(x_unb) > 10'sd0;

  // Normal path: leading one moved to the MSB; top 24 bits are the
  // significand, the rest become guard/round/sticky.
  assign norm = s1_mag << (P_W'(MAG_W - 1) - lead);

  // Denormal path: fraction*8 = mag << (E-1), giving the 23-bit fraction
  // followed by guard, round and sticky. On this path E <= ALIGN_POINT, so
  // the leading one lands at or below bit 25 and a 5-bit shift suffices.
  assign dn = 26'(s1_mag) << (s1_exp[4:0] - 5'd1);

  logic        s2_sign;
  logic [23:0] s2_sig;
  logic        s2_g, s2_r, s2_s;
  logic [9:0]  s2_exp;
  logic        s2_denorm, s2_zero;
  logic        s2_nan, s2_infp, s2_infn;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (load2) begin
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_sig    <= is_norm ? norm[MAG_W-1 -: 24] : {1'b0, dn[25:3]};
      s2_g      <= is_norm ? norm[MAG_W-25] : dn[2];
      s2_r      <= is_norm ? norm[MAG_W-26] : dn[1];
      s2_s      <= is_norm ? (|norm[MAG_W-27:0]) : dn[0];
      s2_exp    <= is_norm ? x_unb : 10'd0;
      s2_denorm <= !is_norm;
      s2_zero   <= (s1_mag == '0);
      s2_nan    <= s1_nan;
      s2_infp   <= s1_infp;
      s2_infn   <= s1_infn;
    end
  end

  // ---------------------------------------------------------------- S3
  logic        inc;
  logic [24:0] rsum;
  logic [9:0]  exp_f;
  logic [22:0] frac;
  logic        ovf;
  logic        inx;

  assign inc  = s2_g & (s2_r | s2_s | s2_sig[0]);
  assign rsum = {1'b0, s2_sig} + 25'(inc);
  // A denormal that carries into bit 23 becomes the smallest normal.
  assign exp_f = s2_denorm ? 10'(rsum[23]) : (s2_exp + 10'(rsum[24]));
  assign frac  = rsum[24] ? rsum[23:1] : rsum[22:0];
  assign ovf   = !s2_denorm && ($signed(exp_f) >= 10'sd255);
  assign inx   = s2_g | s2_r | s2_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3        <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
        inexact   <= 1'b0;
        if (s2_nan || (s2_infp && s2_infn)) begin
          result <= 32'h7FC0_0000;
        end else if (s2_infp) begin
          result <= 32'h7F80_0000;
        end else if (s2_infn) begin
          result <= 32'hFF80_0000;
        end else if (s2_zero) begin
          result <= 32'h0000_0000;
        end else if (ovf) begin
          result   <= {s2_sign, 8'hFF, 23'h0};
          overflow <= 1'b1;
          inexact  <= 1'b1;
        end else begin
          result    <= {s2_sign, exp_f[7:0], frac};
          inexact   <= inx;
          underflow <= inx && (exp_f[7:0] == 8'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_normalizer.sv
// tb/tb_fp32_normalizer.sv - randomized and directed bench for fp32_normalizer
module tb_fp32_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] sum_in;
  logic [7:0]  max_exp_in;
  logic        any_nan_in;
  logic        inf_pos_in;
  logic        inf_neg_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  fp32_normalizer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .max_exp_in (max_exp_in),
    .any_nan_in (any_nan_in),
    .inf_pos_in (inf_pos_in),
    .inf_neg_in (inf_neg_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .inexact    (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] sum;
    logic [7:0]  me;
    logic        nan;
    logic        ip;
    logic        ineg;
    logic        use_k;
    logic [34:0] k;
  } beat_t;

  beat_t       src_q[$];
  logic [34:0] exp_q[$];   // {result, overflow, underflow, inexact}
  int          total = 0;
  int          bad   = 0;
  int          nacc  = 0;
  logic        gap_en = 1'b0;
  logic        last_in_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: value = sign * mag * 2^(E-153); express it in units of the
  // FP32 ulp for its binade and round the integer quotient to nearest-even.
  function automatic logic [34:0] model(input logic [30:0] sum, input logic [7:0] me,
                                        input logic nan, input logic ip, input logic ineg);
    longint mag, q, rem, half, e, eb, p, sh, field, one;
    logic   sgn, inx;
    one = 1;
    if (nan || (ip && ineg)) return {32'h7FC00000, 3'b000};
    if (ip)   return {32'h7F800000, 3'b000};
    if (ineg) return {32'hFF800000, 3'b000};
    sgn = sum[30];
    mag = sgn ? -longint'($signed(sum)) : longint'(sum);
    if (mag == 0) return 35'd0;
    e = (me == 8'd0) ? 1 : longint'(me);
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    eb = e + p - 26;
    if (eb < 1) eb = 1;
    sh = e - 3 - eb;
    rem = 0;
    if (sh >= 0) begin
      q = mag << sh;
    end else begin
      q    = mag >> (-sh);
      rem  = mag & ((one << (-sh)) - 1);
      half = one << (-sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    inx = (rem != 0);
    if (q == (one << 24)) begin
      q = q >> 1;
      eb++;
    end
    field = (q >= (one << 23)) ? eb : 0;
    if (field >= 255) return {sgn, 8'hFF, 23'h0, 3'b101};
    return {sgn, field[7:0], q[22:0], 1'b0, inx && (field == 0), inx};
  endfunction

  task automatic push(input logic [30:0] s, input logic [7:0] me, input logic nan,
                      input logic ip, input logic ineg, input logic use_k, input logic [34:0] k);
    beat_t b;
    b.sum = s; b.me = me; b.nan = nan; b.ip = ip; b.ineg = ineg; b.use_k = use_k; b.k = k;
    src_q.push_back(b);
  endtask

  task automatic push_rand();
    logic [63:0] m;
    logic [30:0] s;
    logic [7:0]  me;
    int          w, ek, kind;
    w = $urandom_range(0, 30);
    m = {$urandom, $urandom} & ((64'd1 << w) - 64'd1);
    s = 31'(m);
    if ($urandom_range(0, 1) == 1) s = -s;
    ek = $urandom_range(0, 3);
    if (ek == 0)      me = 8'($urandom_range(0, 30));
    else if (ek == 1) me = 8'($urandom_range(225, 254));
    else              me = 8'($urandom_range(0, 254));
    kind = $urandom_range(0, 15);
    push(s, me, kind == 0, kind == 1 || kind == 3, kind == 2 || kind == 3, 1'b0, 35'd0);
  endtask

  // One clock cycle: present the head beat, score any output transfer,
  // check held output while stalled, then advance to the next negedge.
  task automatic cycle();
    beat_t       b;
    logic [34:0] e;
    logic        acc, fire;
    if (src_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      b          = src_q[0];
      in_valid   = 1'b1;
      sum_in     = b.sum;
      max_exp_in = b.me;
      any_nan_in = b.nan;
      inf_pos_in = b.ip;
      inf_neg_in = b.ineg;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    last_in_ready = in_ready;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (fire) begin
      chk("have_exp", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e[34:3]));
        chk("flags", 64'({overflow, underflow, inexact}), 64'(e[2:0]));
      end
    end else if (out_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("hold", 64'(result), 64'(e[34:3]));
    end
    if (acc) begin
      b = src_q.pop_front();
      exp_q.push_back(b.use_k ? b.k : model(b.sum, b.me, b.nan, b.ip, b.ineg));
      nacc++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic rand_rdy);
    int k;
    k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < 20000) begin
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      k++;
    end
    chk("drain_left", 64'(src_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base;
    rst = 1'b1; in_valid = 1'b0; sum_in = '0; max_exp_in = '0;
    any_nan_in = 1'b0; inf_pos_in = 1'b0; inf_neg_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Latency with out_ready held high.
    push(31'h4000000, 8'd127, 0, 0, 0, 1, {32'h3F800000, 3'b000});
    cycle();
    chk("lat_accept", 64'(nacc), 64'd1);
    n = 1;
    while (n < 10) begin
      #1;
      if (out_valid) break;
      cycle();
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    drain(0);

    // Directed values and range limits.
    push(31'h74000000, 8'd127, 0, 0, 0, 1, {32'hC0400000, 3'b000});
    push(31'h0000000,  8'd127, 0, 0, 0, 1, {32'h00000000, 3'b000});
    push(31'h4000004,  8'd127, 0, 0, 0, 1, {32'h3F800000, 3'b001});
    push(31'h400000C,  8'd127, 0, 0, 0, 1, {32'h3F800002, 3'b001});
    push(31'h7FFFFFF,  8'd127, 0, 0, 0, 1, {32'h40000000, 3'b001});
    push(31'h3FFFFFFF, 8'd254, 0, 0, 0, 1, {32'h7F800000, 3'b101});
    push(31'h2000000,  8'd1,   0, 0, 0, 1, {32'h00400000, 3'b000});
    push(31'h2000000,  8'd0,   0, 0, 0, 1, {32'h00400000, 3'b000});
    push(31'h3FFFFFF,  8'd1,   0, 0, 0, 1, {32'h00800000, 3'b001});
    push(31'h0000007,  8'd1,   0, 0, 0, 1, {32'h00000001, 3'b011});
    push(31'h4000000,  8'd127, 1, 0, 0, 1, {32'h7FC00000, 3'b000});
    push(31'h4000000,  8'd127, 0, 1, 1, 1, {32'h7FC00000, 3'b000});
    push(31'h0000005,  8'd127, 0, 0, 1, 1, {32'hFF800000, 3'b000});
    push(31'h0000005,  8'd127, 0, 1, 0, 1, {32'h7F800000, 3'b000});
    drain(0);

    // Back-pressure: five beats against a stalled output.
    out_ready = 1'b0;
    base = nacc;
    repeat (5) push_rand();
    repeat (6) cycle();
    chk("stall_accepts", 64'(nacc - base), 64'd3);
    chk("stall_in_ready", 64'(last_in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    drain(0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    base = nacc;
    repeat (3) push_rand();
    repeat (3) cycle();
    chk("midrst_fill", 64'(nacc - base), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) cycle();
    push(31'h4000000, 8'd128, 0, 0, 0, 1, {32'h40000000, 3'b000});
    drain(0);

    // Randomized traffic with input gaps and random back-pressure.
    gap_en = 1'b1;
    repeat (1200) push_rand();
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_normalizer.md
Name: fp32_normalizer

Overview:
- Back-end of the FP32 adder tree; inverse of the front-end alignment step.
- Takes the signed two's-complement sum of the 27-bit aligned mantissas, the shared maximum biased exponent, and special-value flags.
- Normalizes, rounds to nearest-even and packs an IEEE-754 single-precision result.
- 3-stage pipeline with valid/ready handshake on both sides.

Parameters:
- SUM_WIDTH, 31: width of signed sum_in. Covers 8 inputs × 27 bits plus sign.
- ALIGN_POINT, 26: bit index of the implied-1 position in the aligned mantissa. Bits 25..3 are fraction, bits 2..0 are guard.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- sum_in  in  SUM_WIDTH  two's-complement mantissa sum
- max_exp_in  in  8  shared maximum biased exponent
- any_nan_in  in  1  some operand was NaN
- inf_pos_in  in  1  some operand was +inf
- inf_neg_in  in  1  some operand was -inf
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  packed FP32
- overflow  out  1  finite sum rounded to infinity
- underflow  out  1  result is denormal or zero and inexact
- inexact  out  1  nonzero bits discarded by rounding

Behaviour:
- Reset (synchronous, highest priority): all stage valids cleared; out_valid=0, result=0, flags=0; in_ready=1 on the cycle after reset. A reset mid-operation discards every in-flight beat.
- Handshake:
  - A transfer occurs when valid && ready.
  - Stage k loads when its register is empty or its content moves on this cycle.
  - in_ready = !v1 || (v1 moves to S2) — combinational from downstream state.
  - out_valid = v3.
  - result and flags stay stable while out_valid && !out_ready.
  - Latency is exactly 3 cycles from accept to out_valid when out_ready stays high.
  - Throughput 1 beat/cycle. Order is preserved; no drop, no duplication.
- S1 (register):
  - sign = sum_in MSB; mag = |sum_in|, SUM_WIDTH-1 bits.
  - E = (max_exp_in==0) ? 1 : max_exp_in, as 10-bit signed.
  - Special flags are carried forward.
- S2 (normalize):
  - p = index of the leading one of mag, via LZD.
  - Unbounded exponent X = E + p - ALIGN_POINT.
  - If X ≥ 1: normal. Shift mag so bit p lands on bit 23 of a 24-bit significand; collect guard, round and sticky bits.
  - If X < 1: denormal. Output exponent field is 0; fraction = mag shifted by (E-4), left if positive, right if negative; collect guard, round and sticky from shifted-out bits.
  - mag==0: zero path.
- S3 (round/pack):
  - RNE: increment when guard && (round || sticky || lsb).
  - Significand carry-out: shift right 1 and X+1.
  - A denormal that rounds to 1.0×2^-126 becomes exponent field 1.
  - X ≥ 255 after rounding: ±inf 0x7F800000 / 0xFF800000 with the result sign; overflow=1, inexact=1.
  - inexact = guard|round|sticky, or overflow.
  - underflow = inexact && exponent field 0 after rounding.
- Special priority, overriding arithmetic:
  - any_nan_in, or inf_pos_in && inf_neg_in → 0x7FC00000, flags 0.
  - else inf_pos_in → 0x7F800000; inf_neg_in → 0xFF800000; flags 0.
- Zero: mag==0 → 0x00000000 (+0, exact cancellation under RNE), flags 0.

Test Plan:
- sum_in=0x4000000, max_exp_in=127, out_ready=1 → result 0x3F800000 exactly 3 cycles after accept; flags 0.
- sum_in=-(3<<26), max_exp_in=127 → 0xC0400000. Then sum_in=0 → 0x00000000, inexact=0.
- Rounding, max_exp_in=127:
  - sum_in=(1<<26)|0x4 (tie, even lsb) → 0x3F800000, inexact=1.
  - sum_in=(1<<26)|0xC (tie, odd lsb) → 0x3F800002, inexact=1.
- Range limits:
  - max_exp_in=254, sum_in=0x3FFFFFFF → 0x7F800000, overflow=1, inexact=1.
  - max_exp_in=1, sum_in=1<<25 → 0x00400000, underflow=0.
- Specials:
  - any_nan_in=1 → 0x7FC00000.
  - inf_pos_in=inf_neg_in=1 → 0x7FC00000.
  - inf_neg_in=1, sum_in=5 → 0xFF800000.
- Flow control:
  - Push 5 back-to-back beats with out_ready=0 → in_ready falls after 3 accepts.
  - Raise out_ready → all 5 results emerge in order; result is held stable while stalled.
  - Assert rst with 3 beats in flight → out_valid=0 next cycle and none of those beats ever appear.
